// File: rtl/tmcu_gpio_ext.sv
// tmcu_gpio_ext: APB-attached GPIO block with pad direction control,
// set/clear/toggle output helpers, an input synchroniser and per-bit
// edge/level interrupts with a write-one-to-clear status register.
module tmcu_gpio_ext #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [31:0]       paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [WIDTH-1:0]  gpio_in,
  output logic [WIDTH-1:0]  gpio_out,
  output logic [WIDTH-1:0]  gpio_oe,
  output logic              irq
);

  localparam logic [5:0] A_DATA_OUT = 6'h00;
  localparam logic [5:0] A_DIR      = 6'h04;
  localparam logic [5:0] A_DATA_IN  = 6'h08;
  localparam logic [5:0] A_SET      = 6'h0C;
  localparam logic [5:0] A_CLR      = 6'h10;
  localparam logic [5:0] A_TGL      = 6'h14;
  localparam logic [5:0] A_IRQ_EN   = 6'h18;
  localparam logic [5:0] A_IRQ_TYPE = 6'h1C;
  localparam logic [5:0] A_IRQ_POL  = 6'h20;
  localparam logic [5:0] A_IRQ_STAT = 6'h24;

  logic [5:0]       off;
  logic             addr_ok;
  logic             wr_en;
  logic             rd_setup;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] w1c;

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irq_en;
  logic [WIDTH-1:0] irq_type;
  logic [WIDTH-1:0] irq_pol;
  logic [WIDTH-1:0] irq_status;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] set_evt;
  logic [31:0]      rdata_c;

  // Upper address bits and unused write-data bits are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{paddr[31:6], pwdata};

  assign off      = paddr[5:0];
  assign addr_ok  = (off[1:0] == 2'b00) && (off <= A_IRQ_STAT);
  assign wr_en    = psel & penable & pwrite;
  assign rd_setup = psel & ~penable & ~pwrite;
  assign wdata    = pwdata[WIDTH-1:0];
  assign w1c      = (wr_en && off == A_IRQ_STAT) ? wdata : '0;

  assign pready   = 1'b1;
  assign pslverr  = rst_n & psel & penable & ~addr_ok;
  assign gpio_out = data_out;
  assign gpio_oe  = ~dir;
  assign irq      = |(irq_status & irq_en);
  assign din      = sync_q[SYNC_STAGES-1];

  // Pad synchroniser chain plus one-cycle-delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= din;
    end
  end

  // Per-bit interrupt set condition from the selected type and polarity.
  always_comb begin
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] lvl_evt;
    rise     = din & ~prev_q;
    fall     = ~din & prev_q;
    edge_evt = (irq_pol & rise) | (~irq_pol & fall);
    lvl_evt  = (irq_pol & din) | (~irq_pol & ~din);
    set_evt  = (irq_type & edge_evt) | (~irq_type & lvl_evt);
  end

  // Register file writes; a set event overrides a simultaneous W1C.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out   <= '0;
      dir        <= '1;
      irq_en     <= '0;
      irq_type   <= '0;
      irq_pol    <= '0;
      irq_status <= '0;
    end else begin
      if (wr_en) begin
        case (off)
          A_DATA_OUT: data_out <= wdata;
          A_DIR:      dir      <= wdata;
          A_SET:      data_out <= data_out | wdata;
          A_CLR:      data_out <= data_out & ~wdata;
          A_TGL:      data_out <= data_out ^ wdata;
          A_IRQ_EN:   irq_en   <= wdata;
          A_IRQ_TYPE: irq_type <= wdata;
          A_IRQ_POL:  irq_pol  <= wdata;
          default: ;
        endcase
      end
      irq_status <= (irq_status & ~w1c) | set_evt;
    end
  end

  // Read mux; write-only and unmapped offsets return zero.
  always_comb begin
    rdata_c = '0;
    case (off)
      A_DATA_OUT: rdata_c[WIDTH-1:0] = data_out;
      A_DIR:      rdata_c[WIDTH-1:0] = dir;
      A_DATA_IN:  rdata_c[WIDTH-1:0] = din;
      A_IRQ_EN:   rdata_c[WIDTH-1:0] = irq_en;
      A_IRQ_TYPE: rdata_c[WIDTH-1:0] = irq_type;
      A_IRQ_POL:  rdata_c[WIDTH-1:0] = irq_pol;
      A_IRQ_STAT: rdata_c[WIDTH-1:0] = irq_status;
      default: ;
    endcase
  end

  // Read data captured in the setup phase and held through the access phase.
  always_ff @(posedge clk) begin
    if (!rst_n) prdata <= '0;
    else if (rd_setup) prdata <= rdata_c;
  end

endmodule

// File: tb/tb_tmcu_gpio_ext.sv
// Testbench for tmcu_gpio_ext: directed scenarios plus a randomized
// run checked against a behavioural register/interrupt model.
module tb_tmcu_gpio_ext;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata, prdata8;
  logic        pready, pslverr, pready8, pslverr8;
  logic [31:0] gpio_in, gpio_out, gpio_oe;
  logic [7:0]  gpio_out8, gpio_oe8;
  logic        irq, irq8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tmcu_gpio_ext #(.WIDTH(32), .SYNC_STAGES(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_oe(gpio_oe), .irq(irq)
  );

  tmcu_gpio_ext #(.WIDTH(8), .SYNC_STAGES(S)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata8), .pready(pready8),
    .pslverr(pslverr8), .gpio_in(gpio_in[7:0]), .gpio_out(gpio_out8),
    .gpio_oe(gpio_oe8), .irq(irq8)
  );

  // Behavioural model of the 32-bit instance.
  logic [31:0] m_out, m_dir, m_en, m_type, m_pol, m_stat;
  logic [31:0] hist [4];   // hist[k] = pin value sampled k edges ago (after shift)

  always @(posedge clk) begin
    logic [31:0] cur, prv, setv, w1c;
    if (!rst_n) begin
      m_out = 0; m_dir = 32'hFFFF_FFFF; m_en = 0; m_type = 0; m_pol = 0; m_stat = 0;
      for (int i = 0; i < 4; i++) hist[i] = 0;
    end else begin
      cur = hist[S-1];
      prv = hist[S];
      for (int b = 0; b < 32; b++) begin
        if (m_type[b]) setv[b] = m_pol[b] ? (!prv[b] && cur[b]) : (prv[b] && !cur[b]);
        else           setv[b] = (cur[b] == m_pol[b]);
      end
      w1c = 0;
      if (psel && penable && pwrite) begin
        case (paddr[5:0])
          6'h00: m_out  = pwdata;
          6'h04: m_dir  = pwdata;
          6'h0C: m_out  = m_out | pwdata;
          6'h10: m_out  = m_out & ~pwdata;
          6'h14: m_out  = m_out ^ pwdata;
          6'h18: m_en   = pwdata;
          6'h1C: m_type = pwdata;
          6'h20: m_pol  = pwdata;
          6'h24: w1c    = pwdata;
          default: ;
        endcase
      end
      m_stat = (m_stat & ~w1c) | setv;
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = gpio_in;
    end
  end

  function automatic logic [31:0] model_read(input logic [5:0] a);
    case (a)
      6'h00: return m_out;
      6'h04: return m_dir;
      6'h08: return hist[S-1];
      6'h18: return m_en;
      6'h1C: return m_type;
      6'h20: return m_pol;
      6'h24: return m_stat;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic model_err(input logic [5:0] a);
    return (a[1:0] != 2'b00) || (a > 6'h24);
  endfunction

  task automatic bus_idle();
    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
  endtask

  // Called at a negedge, returns at a negedge.
  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
    psel = 1; penable = 0; pwrite = 0; paddr = a;
    @(negedge clk);
    penable = 1;
    #1;
    d = prdata; err = pslverr;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic test_reset();
    rst_n = 0; gpio_in = 0;
    psel = 1; penable = 1; pwrite = 0; paddr = 32'h30; pwdata = 0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (gpio_oe !== 32'h0) begin bad++; $display("FAIL reset_oe got=%h exp=%h", gpio_oe, 32'h0); end
    total++; if (gpio_out !== 32'h0) begin bad++; $display("FAIL reset_out got=%h exp=%h", gpio_out, 32'h0); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    total++; if (pslverr !== 1'b0) begin bad++; $display("FAIL reset_pslverr got=%b exp=0", pslverr); end
    total++; if (prdata !== 32'h0) begin bad++; $display("FAIL reset_prdata got=%h exp=0", prdata); end
    bus_idle();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    begin
      logic [31:0] d; logic e;
      apb_read(32'h04, d, e);
      total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_dir got=%h exp=%h", d, 32'hFFFF_FFFF); end
      total++; if (pready !== 1'b1) begin bad++; $display("FAIL pready got=%b exp=1", pready); end
    end
  endtask

  task automatic test_set_clr_tgl();
    logic [31:0] d; logic e;
    logic [31:0] adr [4] = '{32'h00, 32'h0C, 32'h10, 32'h14};
    logic [31:0] val [4] = '{32'h0F, 32'hF0, 32'h0F, 32'h101};
    logic [31:0] exv [4] = '{32'h0F, 32'hFF, 32'hF0, 32'h1F1};
    apb_write(32'h04, 32'h0000_FFFF);
    for (int i = 0; i < 4; i++) begin
      apb_write(adr[i], val[i]);
      apb_read(32'h00, d, e);
      total++; if (d !== exv[i]) begin bad++; $display("FAIL data_out_step%0d got=%h exp=%h", i, d, exv[i]); end
    end
    apb_read(32'h0C, d, e);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL set_reads_zero got=%h exp=0", d); end
    total++; if (gpio_oe !== 32'hFFFF_0000) begin bad++; $display("FAIL gpio_oe got=%h exp=%h", gpio_oe, 32'hFFFF_0000); end
    total++; if (gpio_out !== 32'h1F1) begin bad++; $display("FAIL gpio_out got=%h exp=%h", gpio_out, 32'h1F1); end
  endtask

  task automatic test_edge_irq();
    logic [31:0] d; logic e;
    apb_write(32'h1C, 32'hFFFF_FFFF);
    apb_write(32'h20, 32'h0000_0008);
    apb_write(32'h18, 32'h0000_0008);
    apb_write(32'h24, 32'hFFFF_FFFF);
    apb_read(32'h24, d, e);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL edge_pre_status got=%h exp=0", d); end
    gpio_in[3] = 1'b1;
    for (int k = 1; k <= S + 1; k++) begin
      @(negedge clk);
      total++;
      if (irq !== (k == S + 1)) begin bad++; $display("FAIL edge_latency cycle%0d got=%b exp=%b", k, irq, (k == S + 1)); end
    end
    apb_read(32'h24, d, e);
    total++; if (d !== 32'h8) begin bad++; $display("FAIL edge_status got=%h exp=%h", d, 32'h8); end
    apb_write(32'h24, 32'h8);
    apb_read(32'h24, d, e);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL edge_w1c got=%h exp=0", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL edge_w1c_irq got=%b exp=0", irq); end
  endtask

  task automatic test_level_w1c();
    logic [31:0] d, ex; logic e;
    apb_write(32'h1C, 32'hFFFF_FFFE);
    apb_write(32'h20, 32'h0000_0020);
    apb_write(32'h24, 32'hFFFF_FFFF);
    apb_write(32'h24, 32'h1);
    ex = model_read(6'h24);
    apb_read(32'h24, d, e);
    total++; if (d[0] !== 1'b1) begin bad++; $display("FAIL level_reset_bit0 got=%b exp=1", d[0]); end
    total++; if (d !== ex) begin bad++; $display("FAIL level_status got=%h exp=%h", d, ex); end
    gpio_in[5] = 1'b1;
    repeat (S - 1) @(negedge clk);
    apb_write(32'h24, 32'h20);
    apb_read(32'h24, d, e);
    total++; if (d[5] !== 1'b1) begin bad++; $display("FAIL set_beats_w1c got=%b exp=1", d[5]); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d, ex; logic e;
    logic [5:0] chk [5] = '{6'h00, 6'h04, 6'h18, 6'h1C, 6'h20};
    apb_read(32'h30, d, e);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL unmapped_err got=%b exp=1", e); end
    total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_data got=%h exp=0", d); end
    apb_read(32'h06, d, e);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL misaligned_err got=%b exp=1", e); end
    apb_read(32'h24, d, e);
    total++; if (e !== 1'b0) begin bad++; $display("FAIL mapped_err got=%b exp=0", e); end
    apb_write(32'h2C, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      ex = model_read(chk[i]);
      apb_read({26'h0, chk[i]}, d, e);
      total++; if (d !== ex) begin bad++; $display("FAIL unmapped_wr_%0h got=%h exp=%h", chk[i], d, ex); end
    end
    total++; if (gpio_out !== 32'h1F1) begin bad++; $display("FAIL unmapped_wr_out got=%h exp=%h", gpio_out, 32'h1F1); end
  endtask

  task automatic test_width8();
    logic [31:0] d; logic e;
    apb_write(32'h00, 32'hFFFF_FFFF);
    apb_read(32'h00, d, e);
    total++; if (prdata8 !== 32'h0000_00FF) begin bad++; $display("FAIL width8_read got=%h exp=%h", prdata8, 32'hFF); end
    total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL width32_read got=%h exp=%h", d, 32'hFFFF_FFFF); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] d; logic e;
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h04; pwdata = 32'h0;
    @(negedge clk);
    penable = 1; rst_n = 0;
    @(negedge clk);
    bus_idle(); rst_n = 1;
    #1;
    total++; if (gpio_oe !== 32'h0) begin bad++; $display("FAIL midreset_oe got=%h exp=0", gpio_oe); end
    total++; if (gpio_out !== 32'h0) begin bad++; $display("FAIL midreset_out got=%h exp=0", gpio_out); end
    @(negedge clk);
    apb_read(32'h04, d, e);
    total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL midreset_dir got=%h exp=%h", d, 32'hFFFF_FFFF); end
  endtask

  task automatic test_random();
    logic [5:0]  offs [14] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h18,
                               6'h1C, 6'h20, 6'h24, 6'h28, 6'h30, 6'h3C, 6'h02};
    logic [31:0] d, ex, r; logic e, exe;
    logic [5:0]  o;
    for (int n = 0; n < 400; n++) begin
      total++;
      if (gpio_out !== m_out || gpio_oe !== ~m_dir || irq !== |(m_stat & m_en)) begin
        bad++;
        $display("FAIL rand_pins n=%0d out=%h/%h oe=%h/%h irq=%b/%b", n, gpio_out, m_out,
                 gpio_oe, ~m_dir, irq, |(m_stat & m_en));
      end
      r = $urandom;
      o = offs[$urandom_range(0, 13)];
      case ($urandom_range(0, 3))
        0: begin gpio_in = $urandom; @(negedge clk); end
        1: apb_write({r[31:6], o}, $urandom);
        default: begin
          ex  = model_read(o);
          exe = model_err(o);
          apb_read({r[31:6], o}, d, e);
          total++;
          if (d !== ex || e !== exe) begin
            bad++;
            $display("FAIL rand_read off=%h got=%h/%b exp=%h/%b", o, d, e, ex, exe);
          end
        end
      endcase
    end
  endtask

  initial begin
    bus_idle();
    gpio_in = 0;
    rst_n = 0;
    @(negedge clk);
    test_reset();
    test_set_clr_tgl();
    test_edge_irq();
    test_level_w1c();
    test_unmapped();
    test_width8();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
